// File: rtl/vga_pkg.sv
// Shared 640x400@70 Hz raster constants, counter widths and the RGB444 pixel type.
package vga_pkg;

  localparam int unsigned HVisible = 640;
  localparam int unsigned HFront   = 16;
  localparam int unsigned HSync    = 96;
  localparam int unsigned HBack    = 48;
  localparam int unsigned VVisible = 400;
  localparam int unsigned VFront   = 12;
  localparam int unsigned VSync    = 2;
  localparam int unsigned VBack    = 35;

  localparam int unsigned HTotal = HVisible + HFront + HSync + HBack;
  localparam int unsigned VTotal = VVisible + VFront + VSync + VBack;

  localparam int unsigned HCntW = $clog2(HTotal);
  localparam int unsigned VCntW = $clog2(VTotal);

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with a synchronous reset value; Depth 0 is a wire.
module vga_delay_line #(
  parameter int unsigned      Width    = 1,
  parameter int unsigned      Depth    = 1,
  parameter logic [Width-1:0] ResetVal = '0
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Depth:0][Width-1:0] w_tap;

  assign w_tap[0] = d_i;

  for (genvar g = 0; g < Depth; g++) begin : g_stage
    logic [Width-1:0] r_stage;
    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        r_stage <= ResetVal;
      end else begin
        r_stage <= w_tap[g];
      end
    end
    assign w_tap[g+1] = r_stage;
  end

  if (Depth == 0) begin : g_pass
    logic w_unused_clk_rst;
    assign w_unused_clk_rst = clk_i & reset_i;
  end

  assign q_o = w_tap[Depth];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster generator: counters, request/sync decode, latency-matched output register.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE     = HVisible,
  parameter int unsigned H_FRONT       = HFront,
  parameter int unsigned H_SYNC        = HSync,
  parameter int unsigned H_BACK        = HBack,
  parameter int unsigned V_VISIBLE     = VVisible,
  parameter int unsigned V_FRONT       = VFront,
  parameter int unsigned V_SYNC        = VSync,
  parameter int unsigned V_BACK        = VBack,
  parameter logic        HSYNC_ACTIVE  = 1'b0,
  parameter logic        VSYNC_ACTIVE  = 1'b1,
  parameter int unsigned PIXEL_LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  output logic        pix_req_o,
  output logic [9:0]  x_o,
  output logic [8:0]  y_o,
  output logic        frame_start_o,
  input  logic [11:0] pixel_i,
  output logic [3:0]  red_o,
  output logic [3:0]  grn_o,
  output logic [3:0]  blu_o,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        disp_en_o
);

  localparam int unsigned HTot = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned VTot = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [HCntW-1:0] HLast   = HCntW'(HTot - 1);
  localparam logic [HCntW-1:0] HVis    = HCntW'(H_VISIBLE);
  localparam logic [HCntW-1:0] HsStart = HCntW'(H_VISIBLE + H_FRONT);
  localparam logic [HCntW-1:0] HsEnd   = HCntW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [VCntW-1:0] VLast   = VCntW'(VTot - 1);
  localparam logic [VCntW-1:0] VVis    = VCntW'(V_VISIBLE);
  localparam logic [VCntW-1:0] VsStart = VCntW'(V_VISIBLE + V_FRONT);
  localparam logic [VCntW-1:0] VsEnd   = VCntW'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [HCntW-1:0] r_h_cnt;
  logic [VCntW-1:0] r_v_cnt;
  logic             w_h_wrap;

  assign w_h_wrap = (r_h_cnt == HLast);

  // Line wrap and row advance share one edge so there is no dead cycle between lines.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else begin
      r_h_cnt <= w_h_wrap ? '0 : r_h_cnt + 1'b1;
      if (w_h_wrap) begin
        r_v_cnt <= (r_v_cnt == VLast) ? '0 : r_v_cnt + 1'b1;
      end
    end
  end

  logic w_pix_req, w_hs, w_vs;

  assign w_pix_req     = (r_h_cnt < HVis) && (r_v_cnt < VVis);
  assign w_hs          = (r_h_cnt >= HsStart) && (r_h_cnt < HsEnd);
  assign w_vs          = (r_v_cnt >= VsStart) && (r_v_cnt < VsEnd);
  assign pix_req_o     = w_pix_req;
  assign x_o           = r_h_cnt;
  assign y_o           = r_v_cnt;
  assign frame_start_o = (r_h_cnt == '0) && (r_v_cnt == '0);

  logic w_hs_d, w_vs_d, w_req_d;

  vga_delay_line #(
    .Width    (3),
    .Depth    (PIXEL_LATENCY),
    .ResetVal (3'b000)
  ) u_delay (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .d_i     ({w_hs, w_vs, w_pix_req}),
    .q_o     ({w_hs_d, w_vs_d, w_req_d})
  );

  rgb444_t w_pix;
  rgb444_t r_rgb;
  logic    r_hsync, r_vsync, r_disp_en;

  assign w_pix = pixel_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_hsync   <= ~HSYNC_ACTIVE;
      r_vsync   <= ~VSYNC_ACTIVE;
      r_disp_en <= 1'b0;
      r_rgb     <= '0;
    end else begin
      r_hsync   <= w_hs_d ? HSYNC_ACTIVE : ~HSYNC_ACTIVE;
      r_vsync   <= w_vs_d ? VSYNC_ACTIVE : ~VSYNC_ACTIVE;
      r_disp_en <= w_req_d;
      r_rgb     <= w_req_d ? w_pix : '0;
    end
  end

  assign red_o     = r_rgb.r;
  assign grn_o     = r_rgb.g;
  assign blu_o     = r_rgb.b;
  assign hsync_o   = r_hsync;
  assign vsync_o   = r_vsync;
  assign disp_en_o = r_disp_en;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default raster at latencies 2/0/7 plus a tiny raster for frame-level timing.
module tb_vga_timing_gen;

  typedef struct packed {
    int hv; int hf; int hs; int hb;
    int vv; int vf; int vs; int vb;
    int lat;
  } geom_t;

  localparam int NDut = 4;

  logic clk = 1'b0;
  logic reset;
  always #20 clk = ~clk;

  logic [NDut-1:0]        pix_req, fs, hsync, vsync, de;
  logic [NDut-1:0][9:0]   x;
  logic [NDut-1:0][8:0]   y;
  logic [NDut-1:0][11:0]  pixel;
  logic [NDut-1:0][3:0]   red, grn, blu;

  vga_timing_gen #(.PIXEL_LATENCY(2)) u_main (
    .clk_i(clk), .reset_i(reset), .pix_req_o(pix_req[0]), .x_o(x[0]), .y_o(y[0]),
    .frame_start_o(fs[0]), .pixel_i(pixel[0]), .red_o(red[0]), .grn_o(grn[0]),
    .blu_o(blu[0]), .hsync_o(hsync[0]), .vsync_o(vsync[0]), .disp_en_o(de[0])
  );

  vga_timing_gen #(.PIXEL_LATENCY(0)) u_lat0 (
    .clk_i(clk), .reset_i(reset), .pix_req_o(pix_req[1]), .x_o(x[1]), .y_o(y[1]),
    .frame_start_o(fs[1]), .pixel_i(pixel[1]), .red_o(red[1]), .grn_o(grn[1]),
    .blu_o(blu[1]), .hsync_o(hsync[1]), .vsync_o(vsync[1]), .disp_en_o(de[1])
  );

  vga_timing_gen #(.PIXEL_LATENCY(7)) u_lat7 (
    .clk_i(clk), .reset_i(reset), .pix_req_o(pix_req[2]), .x_o(x[2]), .y_o(y[2]),
    .frame_start_o(fs[2]), .pixel_i(pixel[2]), .red_o(red[2]), .grn_o(grn[2]),
    .blu_o(blu[2]), .hsync_o(hsync[2]), .vsync_o(vsync[2]), .disp_en_o(de[2])
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .PIXEL_LATENCY(2)
  ) u_small (
    .clk_i(clk), .reset_i(reset), .pix_req_o(pix_req[3]), .x_o(x[3]), .y_o(y[3]),
    .frame_start_o(fs[3]), .pixel_i(pixel[3]), .red_o(red[3]), .grn_o(grn[3]),
    .blu_o(blu[3]), .hsync_o(hsync[3]), .vsync_o(vsync[3]), .disp_en_o(de[3])
  );

  int n_checks = 0;
  int n_fail   = 0;
  int k;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (k=%0d)", tag, obs, exp, k);
    end
  endtask

  function automatic geom_t geom(input int i);
    geom_t g;
    g = '{hv: 640, hf: 16, hs: 96, hb: 48, vv: 400, vf: 12, vs: 2, vb: 35, lat: 2};
    case (i)
      1: g.lat = 0;
      2: g.lat = 7;
      3: g = '{hv: 8, hf: 2, hs: 3, hb: 2, vv: 4, vf: 1, vs: 2, vb: 1, lat: 2};
      default: ;
    endcase
    return g;
  endfunction

  function automatic string dut_name(input int i);
    case (i)
      0: return "main";
      1: return "lat0";
      2: return "lat7";
      default: return "small";
    endcase
  endfunction

  // Expected {hsync, vsync, disp_en, rgb} for output cycle k (k=0: first cycle after reset).
  function automatic logic [14:0] exp_reg(input geom_t g, input int k_i);
    int j, ht, vt, h, v;
    logic [31:0] hl, vl;
    logic hs, vs, req;
    if (k_i < g.lat + 1) return {1'b1, 1'b0, 1'b0, 12'h000};
    j  = k_i - g.lat - 1;
    ht = g.hv + g.hf + g.hs + g.hb;
    vt = g.vv + g.vf + g.vs + g.vb;
    h  = j % ht;
    v  = (j / ht) % vt;
    hl = h;
    vl = v;
    req = (h < g.hv) && (v < g.vv);
    hs  = (h >= g.hv + g.hf) && (h < g.hv + g.hf + g.hs);
    vs  = (v >= g.vv + g.vf) && (v < g.vv + g.vf + g.vs);
    return {~hs, vs, req, req ? {hl[3:0], vl[3:0], 4'hA} : 12'h000};
  endfunction

  // Upstream source: coordinate-tagged colour after lat cycles, all-ones when idle.
  function automatic logic [11:0] src_pix(input geom_t g, input int k_i);
    int j, ht, vt, h, v;
    logic [31:0] hl, vl;
    j = k_i - g.lat;
    if (j < 0) return 12'hFFF;
    ht = g.hv + g.hf + g.hs + g.hb;
    vt = g.vv + g.vf + g.vs + g.vb;
    h  = j % ht;
    v  = (j / ht) % vt;
    hl = h;
    vl = v;
    if ((h < g.hv) && (v < g.vv)) return {hl[3:0], vl[3:0], 4'hA};
    return 12'hFFF;
  endfunction

  task automatic drive_pixels();
    for (int i = 0; i < NDut; i++) pixel[i] = src_pix(geom(i), k);
  endtask

  task automatic check_cycle();
    for (int i = 0; i < NDut; i++) begin
      geom_t g;
      int ht, vt, h, v;
      logic [31:0] hl, vl;
      logic req, fst;
      g   = geom(i);
      ht  = g.hv + g.hf + g.hs + g.hb;
      vt  = g.vv + g.vf + g.vs + g.vb;
      h   = k % ht;
      v   = (k / ht) % vt;
      hl  = h;
      vl  = v;
      req = (h < g.hv) && (v < g.vv);
      fst = (h == 0) && (v == 0);
      check_eq({dut_name(i), ".reg"},
               {hsync[i], vsync[i], de[i], red[i], grn[i], blu[i]}, exp_reg(g, k));
      check_eq({dut_name(i), ".req_fs"}, {pix_req[i], fs[i]}, {req, fst});
      if (req) check_eq({dut_name(i), ".xy"}, {x[i], y[i]}, {hl[9:0], vl[8:0]});
    end
  endtask

  int first_de [NDut];
  int cnt_de [NDut];
  int cnt_hs [NDut];
  int first_hs, line1_de, small_vs, small_de, small_fs, last_fs;

  task automatic clear_stats();
    for (int i = 0; i < NDut; i++) begin
      first_de[i] = -1;
      cnt_de[i]   = 0;
      cnt_hs[i]   = 0;
    end
    first_hs = -1;
    line1_de = -1;
    small_vs = 0;
    small_de = 0;
    small_fs = 0;
    last_fs  = -1;
  endtask

  task automatic track();
    for (int i = 0; i < 3; i++) begin
      if (de[i] && first_de[i] < 0) first_de[i] = k;
      if (k < 800 && de[i]) cnt_de[i]++;
      if (k < 800 && !hsync[i]) cnt_hs[i]++;
    end
    if (de[3] && first_de[3] < 0) first_de[3] = k;
    if (!hsync[0] && first_hs < 0) first_hs = k;
    if (k >= 800 && de[0] && line1_de < 0) line1_de = k;
    if (k < 120 && vsync[3]) small_vs++;
    if (k < 120 && de[3]) small_de++;
    if (fs[3]) begin
      if (last_fs >= 0) check_eq("small.fs_period", k - last_fs, 120);
      last_fs = k;
      small_fs++;
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      drive_pixels();
      check_cycle();
      track();
      @(posedge clk);
      #1;
      k++;
    end
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NDut; i++) begin
        check_eq({dut_name(i), ".rst_reg"},
                 {hsync[i], vsync[i], de[i], red[i], grn[i], blu[i]}, 15'h4000);
        check_eq({dut_name(i), ".rst_cnt"}, {pix_req[i], fs[i], x[i], y[i]}, 21'h180000);
      end
    end
    reset = 1'b0;
    k = 0;
    clear_stats();
  endtask

  initial begin
    reset = 1'b1;
    pixel = '1;
    k = 0;
    clear_stats();
    apply_reset(5);

    // Stop in the middle of line 3's hsync pulse so the reset must cut it short.
    run(3100);
    check_eq("main.first_de", first_de[0], 3);
    check_eq("lat0.first_de", first_de[1], 1);
    check_eq("lat7.first_de", first_de[2], 8);
    check_eq("main.first_hs", first_hs, 659);
    check_eq("main.line_period", line1_de - first_de[0], 800);
    for (int i = 0; i < 3; i++) begin
      check_eq({dut_name(i), ".de_per_line"}, cnt_de[i], 640);
      check_eq({dut_name(i), ".hs_width"}, cnt_hs[i], 96);
    end
    check_eq("small.vs_per_frame", small_vs, 30);
    check_eq("small.de_per_frame", small_de, 32);
    check_eq("small.fs_count", small_fs, 26);
    check_eq("main.hs_before_rst", {31'd0, hsync[0]}, 0);

    apply_reset(1);
    run(400);
    check_eq("small.first_de_restart", first_de[3], 3);
    check_eq("small.fs_count_restart", small_fs, 4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
